arb21_rr: RTL and testbench
===========================

# arb21_rr

Round-robin arbiter and sequencer for the shared 2:1 select datapath. Two requesters present packets of WIDTH-bit beats. The block grants the channel to one requester at a time and drives the select line `s` for the `y = s ? d1 : d0` mux. It forwards beats downstream under a valid/ready handshake and enforces a maximum burst length so neither requester can starve the other.

## Interface
Parameters:
- WIDTH, 8, data beat width in bits.
- MAXBURST, 4, maximum beats per grant. Must be ≥1. The burst counter is $clog2(MAXBURST+1) bits.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req0, req1  input  1  requester n has a beat available on dn.
- d0, d1  input  WIDTH  beat data from requester 0 / 1.
- last0, last1  input  1  current beat on dn is the final beat of its packet.
- gnt0, gnt1  output  1  beat on dn is accepted this cycle (requester advances).
- y  output  WIDTH  muxed data, equal to `s ? d1 : d0`.
- y_valid  output  1  y holds a valid beat.
- y_ready  input  1  downstream accepts y this cycle.
- s  output  1  mux select, registered.
- busy  output  1  a grant is currently held.

## Operation
- The FSM has three states: IDLE, G0 and G1.
- Round-robin pointer `ptr` names the favoured requester. The favoured requester wins when both requests are asserted on the same cycle.
- **IDLE:**
  - If only reqn is asserted, go to Gn.
  - If both are asserted, go to G(ptr).
  - If neither is asserted, stay in IDLE.
  - On entry to Gn, set s=n and clear the burst counter.
- **Gn (holding the grant):**
  - y_valid = reqn.
  - gntn = reqn & y_ready. gnt of the other requester is 0.
  - A transfer is reqn & y_ready. Each transfer increments the counter.
- **Release from Gn** happens on any of these conditions:
  - (a) a transfer with lastn=1;
  - (b) a transfer that makes the count reach MAXBURST;
  - (c) reqn=0, i.e. the requester withdrew. A withdrawal releases even mid-packet.
- **On release:**
  - ptr becomes the other requester (1-n).
  - If the other request is asserted in that cycle, go directly to G(1-n): s=1-n and the counter is cleared. There is no idle bubble.
  - Otherwise, when the release was (a) or (b) and reqn is still asserted, re-enter Gn with the counter cleared.
  - Otherwise go to IDLE.
- A packet truncated by MAXBURST resumes on its next grant. The arbiter does not track packet state across grants.
- In IDLE, s holds its last value and y_valid, gnt0, gnt1 are all 0.
- busy = (state != IDLE).
- y is combinational from s, d0, d1 and is unqualified whenever y_valid=0.
- y_valid and gntn are combinational from the registered state and the current reqn / y_ready.

## Timing
- **Reset (rst_n=0), asynchronous:**
  - state=IDLE, ptr=0, s=0, counter=0.
  - busy=0, y_valid=0, gnt0=0, gnt1=0.
  - y=d0.
- **Grant latency:** a request seen in IDLE at edge k gives busy=1 and s set after edge k. The first transfer can occur in cycle k+1.
- **Backpressure:** y_ready=0 stalls the grant indefinitely. The counter, s and state hold, and gnt stays 0. y_valid stays asserted while reqn holds.
- **Switch:** a release at edge k takes effect after edge k, so the new requester's first transfer can occur in cycle k+1. This gives one beat per cycle of sustained throughput across grant changes.
- **Simultaneous events:**
  - last and MAXBURST on the same beat count as a single release.
  - When the holder is released while both requests are asserted, the other requester wins.
- **Reset mid-grant:** outputs return immediately to their reset values. The in-flight packet is abandoned.

## Test plan
- **Single packet, requester 0:** req0 with 3 beats (A1, A2, A3; last on A3), y_ready=1 → busy after 1 cycle, s=0, y=A1, A2, A3 on consecutive cycles with gnt0=1, then IDLE with busy=0.
- **Simultaneous requests from reset:** req0 and req1 rise together, each with a 2-beat packet → requester 0 is served first (ptr=0), s switches to 1 with no bubble, requester 1 is served, and the final ptr is 0.
- **Burst limit:** MAXBURST=4, requester 0 sends a 6-beat packet while req1 is pending → 4 beats from d0, then requester 1's packet, then the remaining 2 beats from d0.
- **Backpressure:** hold y_ready=0 for 3 cycles mid-packet → y, s and the counter are stable, gnt0=0 throughout, and there is no beat loss or duplication.
- **Withdrawal:** req0 drops after 1 of 3 beats while req1 is pending → grant passes to requester 1 on the next cycle.
- **Reset mid-grant:** assert rst_n=0 during G1 → s=0, busy=0, y_valid=0 immediately, and the next arbitration favours requester 0.

Source files
------------

// File: rtl/arb21_rr.sv
// arb21_rr: two-requester round-robin arbiter driving the select of a
// shared 2:1 datapath mux, with valid/ready forwarding and a burst cap.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   req0/req1       requester has a beat on d0/d1
//   d0/d1           beat data
//   last0/last1     beat is final beat of its packet
//   gnt0/gnt1       beat accepted this cycle
//   y, y_valid      muxed beat and its valid
//   y_ready         downstream accepts y
//   s               registered mux select
//   busy            a grant is held
module arb21_rr #(
    parameter int WIDTH    = 8,
    parameter int MAXBURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             last0,
    input  logic             last1,
    output logic             gnt0,
    output logic             gnt1,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    input  logic             y_ready,
    output logic             s,
    output logic             busy
);

    localparam int CW = $clog2(MAXBURST + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAXBURST);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            ptr_q, ptr_d;
    logic            s_q, s_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   cnt_inc;

    logic            hold_id;
    logic            hold_req;
    logic            hold_last;
    logic            other_req;
    logic            xfer;
    logic            rel;
    logic            pick;

    assign cnt_inc = cnt_q + CNT_ONE;
    assign y       = s_q ? d1 : d0;
    assign s       = s_q;
    assign busy    = (state_q != IDLE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            s_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        rel     = 1'b0;
        pick    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    pick    = (req0 && req1) ? ptr_q : req1;
                    state_d = pick ? G1 : G0;
                    s_d     = pick;
                    cnt_d   = '0;
                end
            end
            G0, G1: begin
                // Withdrawal releases even mid-packet.
                rel = (xfer && (hold_last || cnt_inc == CNT_MAX))
                    || !hold_req;
                if (rel) begin
                    ptr_d = ~hold_id;
                    cnt_d = '0;
                    if (other_req) begin
                        // Hand over with no idle bubble.
                        state_d = hold_id ? G0 : G1;
                        s_d     = ~hold_id;
                    end else if (hold_req) begin
                        // Only reachable on last/limit release:
                        // restart a fresh burst for the same side.
                        state_d = state_q;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (xfer) begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode
    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        y_valid   = 1'b0;
        hold_id   = 1'b0;
        hold_req  = 1'b0;
        hold_last = 1'b0;
        other_req = 1'b0;
        unique case (1'b1)
            (state_q == G0): begin
                hold_id   = 1'b0;
                hold_req  = req0;
                hold_last = last0;
                other_req = req1;
                y_valid   = req0;
                gnt0      = req0 & y_ready;
            end
            (state_q == G1): begin
                hold_id   = 1'b1;
                hold_req  = req1;
                hold_last = last1;
                other_req = req0;
                y_valid   = req1;
                gnt1      = req1 & y_ready;
            end
            default: begin
            end
        endcase
        xfer = y_valid & y_ready;
    end

endmodule

// File: tb/tb_arb21_rr.sv
// tb_arb21_rr: directed vector bench for arb21_rr.
// Table of per-cycle vectors plus hand sequences for stall and reset.
module tb_arb21_rr;

    logic       clk;
    logic       rst_n;
    logic       req0, req1;
    logic [7:0] d0, d1;
    logic       last0, last1;
    logic       gnt0, gnt1;
    logic [7:0] y;
    logic       y_valid;
    logic       y_ready;
    logic       s;
    logic       busy;

    int checks = 0;
    int errors = 0;

    arb21_rr #(.WIDTH(8), .MAXBURST(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req0    (req0),
        .req1    (req1),
        .d0      (d0),
        .d1      (d1),
        .last0   (last0),
        .last1   (last1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .y       (y),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .s       (s),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       r0;
        logic       r1;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       l0;
        logic       l1;
        logic       rdy;
        logic       g0;
        logic       g1;
        logic       yv;
        logic       s;
        logic       busy;
        logic [7:0] y;
    } vec_t;

    function automatic vec_t v(
        input logic rn, input logic r0, input logic r1,
        input logic [7:0] a, input logic [7:0] b,
        input logic l0, input logic l1, input logic rdy,
        input logic g0, input logic g1, input logic yv,
        input logic ss, input logic bz, input logic [7:0] yy
    );
        vec_t t;
        t.rst_n = rn; t.r0 = r0; t.r1 = r1;
        t.d0 = a; t.d1 = b; t.l0 = l0; t.l1 = l1;
        t.rdy = rdy; t.g0 = g0; t.g1 = g1; t.yv = yv;
        t.s = ss; t.busy = bz; t.y = yy;
        return t;
    endfunction

    task automatic chk(
        input string nm, input int idx,
        input logic [12:0] got, input logic [12:0] exp
    );
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got g0,g1,yv,s,busy=%b y=%h exp g0,g1,yv,s,busy=%b y=%h",
                     nm, idx, got[12:8], got[7:0], exp[12:8], exp[7:0]);
        end
    endtask

    function automatic logic [12:0] outs();
        return {gnt0, gnt1, y_valid, s, busy, y};
    endfunction

    function automatic logic [12:0] expv(input vec_t t);
        return {t.g0, t.g1, t.yv, t.s, t.busy, t.y};
    endfunction

    task automatic drive(input vec_t t);
        rst_n   = t.rst_n;
        req0    = t.r0;
        req1    = t.r1;
        d0      = t.d0;
        d1      = t.d1;
        last0   = t.l0;
        last1   = t.l1;
        y_ready = t.rdy;
    endtask

    // Inputs change just after falling edge; outputs sampled 2ns later.
    task automatic apply(input vec_t t, input string nm, input int idx);
        drive(t);
        #2;
        chk(nm, idx, outs(), expv(t));
        @(posedge clk);
        @(negedge clk);
    endtask

    vec_t tbl[$];

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        drive(v(0,0,0,8'h00,8'h00,0,0,1, 0,0,0,0,0,8'h00));
        @(negedge clk);

        // reset state
        tbl.push_back(v(0,0,0,8'h00,8'h00,0,0,1, 0,0,0,0,0,8'h00));
        // single 3-beat packet from requester 0
        tbl.push_back(v(1,1,0,8'hA1,8'h00,0,0,1, 0,0,0,0,0,8'hA1));
        tbl.push_back(v(1,1,0,8'hA1,8'h00,0,0,1, 1,0,1,0,1,8'hA1));
        tbl.push_back(v(1,1,0,8'hA2,8'h00,0,0,1, 1,0,1,0,1,8'hA2));
        tbl.push_back(v(1,1,0,8'hA3,8'h00,1,0,1, 1,0,1,0,1,8'hA3));
        tbl.push_back(v(1,0,0,8'h00,8'h00,0,0,1, 0,0,0,0,1,8'h00));
        tbl.push_back(v(1,0,0,8'h00,8'h00,0,0,1, 0,0,0,0,0,8'h00));
        // reset, then simultaneous 2-beat packets
        tbl.push_back(v(0,0,0,8'h00,8'h00,0,0,1, 0,0,0,0,0,8'h00));
        tbl.push_back(v(1,1,1,8'hB1,8'hC1,0,0,1, 0,0,0,0,0,8'hB1));
        tbl.push_back(v(1,1,1,8'hB1,8'hC1,0,0,1, 1,0,1,0,1,8'hB1));
        tbl.push_back(v(1,1,1,8'hB2,8'hC1,1,0,1, 1,0,1,0,1,8'hB2));
        tbl.push_back(v(1,0,1,8'h00,8'hC1,0,0,1, 0,1,1,1,1,8'hC1));
        tbl.push_back(v(1,0,1,8'h00,8'hC2,0,1,1, 0,1,1,1,1,8'hC2));
        tbl.push_back(v(1,0,0,8'h00,8'hC2,0,0,1, 0,0,0,1,1,8'hC2));
        tbl.push_back(v(1,0,0,8'h00,8'h00,0,0,1, 0,0,0,1,0,8'h00));
        // ptr back at 0: 6-beat packet capped at 4, req1 pending
        tbl.push_back(v(1,1,1,8'h51,8'h61,0,0,1, 0,0,0,1,0,8'h61));
        tbl.push_back(v(1,1,1,8'h51,8'h61,0,0,1, 1,0,1,0,1,8'h51));
        tbl.push_back(v(1,1,1,8'h52,8'h61,0,0,1, 1,0,1,0,1,8'h52));
        tbl.push_back(v(1,1,1,8'h53,8'h61,0,0,1, 1,0,1,0,1,8'h53));
        tbl.push_back(v(1,1,1,8'h54,8'h61,0,0,1, 1,0,1,0,1,8'h54));
        tbl.push_back(v(1,1,1,8'h55,8'h61,0,0,1, 0,1,1,1,1,8'h61));
        tbl.push_back(v(1,1,1,8'h55,8'h62,0,1,1, 0,1,1,1,1,8'h62));
        tbl.push_back(v(1,1,0,8'h55,8'h00,0,0,1, 1,0,1,0,1,8'h55));
        tbl.push_back(v(1,1,0,8'h56,8'h00,1,0,1, 1,0,1,0,1,8'h56));
        tbl.push_back(v(1,0,0,8'h00,8'h00,0,0,1, 0,0,0,0,1,8'h00));
        // withdrawal after 1 beat with req1 pending
        tbl.push_back(v(1,1,0,8'h71,8'h00,0,0,1, 0,0,0,0,0,8'h71));
        tbl.push_back(v(1,1,1,8'h71,8'h81,0,0,1, 1,0,1,0,1,8'h71));
        tbl.push_back(v(1,0,1,8'h72,8'h81,0,0,1, 0,0,0,0,1,8'h72));
        tbl.push_back(v(1,0,1,8'h72,8'h81,0,1,1, 0,1,1,1,1,8'h81));
        tbl.push_back(v(1,0,0,8'h00,8'h81,0,0,1, 0,0,0,1,1,8'h81));
        tbl.push_back(v(1,0,0,8'h00,8'h00,0,0,1, 0,0,0,1,0,8'h00));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], "tbl", i);
        end

        // Backpressure mid-packet; req1 pending exposes a
        // counter that moved during the stall.
        apply(v(1,1,1,8'h91,8'hE1,0,0,1, 0,0,0,1,0,8'hE1), "bp", 0);
        apply(v(1,1,1,8'h91,8'hE1,0,0,1, 1,0,1,0,1,8'h91), "bp", 1);
        for (int i = 0; i < 3; i++) begin
            apply(v(1,1,1,8'h92,8'hE1,0,0,0, 0,0,1,0,1,8'h92), "bp_stall", i);
        end
        apply(v(1,1,1,8'h92,8'hE1,0,0,1, 1,0,1,0,1,8'h92), "bp", 2);
        apply(v(1,1,1,8'h93,8'hE1,0,0,1, 1,0,1,0,1,8'h93), "bp", 3);
        apply(v(1,1,1,8'h94,8'hE1,0,0,1, 1,0,1,0,1,8'h94), "bp", 4);
        apply(v(1,1,1,8'h95,8'hE1,0,0,1, 0,1,1,1,1,8'hE1), "bp", 5);

        // Reset asserted mid-cycle while holding G1.
        drive(v(1,1,1,8'h95,8'hE2,0,0,1, 0,0,0,0,0,8'h00));
        #2;
        chk("pre_rst", 0, outs(), {5'b01111, 8'hE2});
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_now", 0, outs(), {5'b00000, 8'h95});
        @(posedge clk);
        @(negedge clk);
        apply(v(1,1,1,8'h95,8'hE2,0,0,1, 0,0,0,0,0,8'h95), "rst_idle", 0);
        apply(v(1,1,1,8'h95,8'hE2,0,0,1, 1,0,1,0,1,8'h95), "rst_fav0", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
